// File: rtl/cam_cfg_pkg.sv
// ---------------------------------------------------------------------------
// cam_cfg_pkg
// Shared types and helpers for the camera configuration sequencer: the FSM
// state enum and the table-entry decode functions (END / DELAY markers).
// ---------------------------------------------------------------------------
package cam_cfg_pkg;

    // Sequencer states, shared so the top and any debug logic agree on encoding
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

    // Widest table entry the decode helpers handle; callers zero-extend to this
    localparam int ENTRY_MAXW = 64;

    // True when entry bits [lo +: width] are all ones
    function automatic logic field_ones(input logic [ENTRY_MAXW-1:0] entry,
                                        input int lo, input int width);
        logic ones;
        ones = 1'b1;
        for (int i = 0; i < ENTRY_MAXW; i++) begin
            if (i >= lo && i < lo + width && !entry[i]) begin
                ones = 1'b0;
            end
        end
        return ones;
    endfunction

    // END marker: register field and data field both all ones
    function automatic logic is_end(input logic [ENTRY_MAXW-1:0] entry,
                                    input int regAw, input int regDw);
        return field_ones(entry, regDw, regAw) && field_ones(entry, 0, regDw);
    endfunction

    // DELAY marker: register field all ones, data field anything else
    function automatic logic is_delay(input logic [ENTRY_MAXW-1:0] entry,
                                      input int regAw, input int regDw);
        return field_ones(entry, regDw, regAw) && !field_ones(entry, 0, regDw);
    endfunction

endpackage

// File: rtl/cam_config_seq_if.sv
// ---------------------------------------------------------------------------
// cam_config_seq_if
// Register-write request bus between the configuration sequencer (master)
// and the SCCB master (slave): valid/ready request, then a done/nack reply.
// ---------------------------------------------------------------------------
interface cam_config_seq_if #(
    parameter int REG_AW = 8,
    parameter int REG_DW = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [7:0]        wr_dev;
    logic [REG_AW-1:0] wr_reg;
    logic [REG_DW-1:0] wr_data;
    logic              wr_done;
    logic              wr_nack;

    modport master (
        output wr_valid, wr_dev, wr_reg, wr_data,
        input  wr_ready, wr_done, wr_nack
    );

    modport slave (
        input  wr_valid, wr_dev, wr_reg, wr_data,
        output wr_ready, wr_done, wr_nack
    );
endinterface

// File: rtl/cam_cfg_delay_timer.sv
// ---------------------------------------------------------------------------
// cam_cfg_delay_timer
// Down-counter for DELAY table entries. load_i presets the count to
// DELAY_CYCLES; while count_i is high it decrements, and expire_o marks the
// final counting cycle so the owner spends exactly DELAY_CYCLES cycles there.
// ---------------------------------------------------------------------------
module cam_cfg_delay_timer #(
    parameter int DELAY_CYCLES = 1_250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);
    localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    // Preset on load, count down while enabled, hold at zero otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= LOAD_VAL;
        end else if (count_i && count_q != '0) begin
            count_q <= count_q - CNT_ONE;
        end
    end

    assign expire_o = count_i && (count_q == CNT_ONE);

endmodule

// File: rtl/cam_config_seq.sv
// ---------------------------------------------------------------------------
// cam_config_seq
// Walks a synchronous-read configuration table and issues one SCCB register
// write per entry. Handles END and DELAY markers, restart requests, NACK
// errors and (optionally) bounded retries.
// Optional feature macro: CAM_CFG_RETRY_EN -- when defined, a NACKed entry is
// reissued up to MAX_RETRY extra times before the sequence aborts.
// ---------------------------------------------------------------------------
module cam_config_seq
    import cam_cfg_pkg::*;
#(
    parameter int         ROM_AW       = 8,
    parameter int         REG_AW       = 8,
    parameter int         REG_DW       = 8,
    parameter logic [7:0] DEV_ID       = 8'h42,
    parameter int         DELAY_CYCLES = 1_250_000,
    parameter int         MAX_RETRY    = 3,
    parameter int         AUTO_START   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    output logic [ROM_AW-1:0]        rom_addr_o,
    input  logic [REG_AW+REG_DW-1:0] rom_data_i,
    cam_config_seq_if.master         wr,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [ROM_AW-1:0]        err_addr_o
);

    localparam logic [ROM_AW-1:0] INDEX_LAST = '1;
    localparam logic [ROM_AW-1:0] INDEX_ONE  = ROM_AW'(1);

`ifdef CAM_CFG_RETRY_EN
    localparam int ATT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRY);
    localparam logic [ATT_W-1:0] ATT_ONE = ATT_W'(1);
    logic [ATT_W-1:0] attempt_q;
`else
    localparam int unusedMaxRetry = MAX_RETRY;
`endif

    state_t                  state_q;
    logic [ROM_AW-1:0]       index_q;
    logic [ROM_AW-1:0]       index_d;
    logic [ROM_AW-1:0]       errAddr_q;
    logic                    wrValid_q;
    logic [REG_AW-1:0]       wrReg_q;
    logic [REG_DW-1:0]       wrData_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic                    restartPend_q;
    logic                    autoPend_q;
    logic [ENTRY_MAXW-1:0]   entryWide;
    logic                    entryIsEnd;
    logic                    entryIsDelay;
    logic                    restartNow;
    logic                    delayLoad;
    logic                    delayCount;
    logic                    delayExpire;

    assign entryWide    = ENTRY_MAXW'(rom_data_i);
    assign entryIsEnd   = is_end(entryWide, REG_AW, REG_DW);
    assign entryIsDelay = is_delay(entryWide, REG_AW, REG_DW);
    assign index_d      = index_q + INDEX_ONE;

    // A restart is taken at once everywhere except while a bus request is
    // outstanding; there it is deferred until the transaction's wr_done.
    assign restartNow = (start_i && state_q != S_ISSUE && state_q != S_WAIT_ACK)
                     || (state_q == S_IDLE && autoPend_q);

    assign delayLoad  = (state_q == S_DECODE) && entryIsDelay;
    assign delayCount = (state_q == S_DELAY);

    cam_cfg_delay_timer #(
        .DELAY_CYCLES (DELAY_CYCLES)
    ) u_delay_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (delayLoad),
        .count_i  (delayCount),
        .expire_o (delayExpire)
    );

    // Main sequencer FSM; every output is a register updated on its transitions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            index_q       <= '0;
            errAddr_q     <= '0;
            wrValid_q     <= 1'b0;
            wrReg_q       <= '0;
            wrData_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            restartPend_q <= 1'b0;
            autoPend_q    <= (AUTO_START != 0);
`ifdef CAM_CFG_RETRY_EN
            attempt_q     <= '0;
`endif
        end else begin
            autoPend_q <= 1'b0;
            if (restartNow) begin
                state_q       <= S_FETCH;
                index_q       <= '0;
                busy_q        <= 1'b1;
                done_q        <= 1'b0;
                error_q       <= 1'b0;
                wrValid_q     <= 1'b0;
                restartPend_q <= 1'b0;
`ifdef CAM_CFG_RETRY_EN
                attempt_q     <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERROR: begin
                        state_q <= state_q;
                    end
                    S_FETCH: begin
                        state_q <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (entryIsEnd) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (entryIsDelay) begin
                            state_q <= S_DELAY;
                        end else begin
                            state_q   <= S_ISSUE;
                            wrValid_q <= 1'b1;
                            wrReg_q   <= rom_data_i[REG_DW +: REG_AW];
                            wrData_q  <= rom_data_i[REG_DW-1:0];
                        end
                    end
                    S_ISSUE: begin
                        if (start_i) begin
                            restartPend_q <= 1'b1;
                        end
                        if (wr.wr_ready) begin
                            state_q   <= S_WAIT_ACK;
                            wrValid_q <= 1'b0;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (start_i) begin
                            restartPend_q <= 1'b1;
                        end
                        if (wr.wr_done) begin
                            if (restartPend_q || start_i) begin
                                state_q       <= S_FETCH;
                                index_q       <= '0;
                                done_q        <= 1'b0;
                                error_q       <= 1'b0;
                                restartPend_q <= 1'b0;
`ifdef CAM_CFG_RETRY_EN
                                attempt_q     <= '0;
`endif
                            end else if (!wr.wr_nack) begin
`ifdef CAM_CFG_RETRY_EN
                                attempt_q <= '0;
`endif
                                if (index_q == INDEX_LAST) begin
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= S_FETCH;
                                    index_q <= index_d;
                                end
                            end else begin
`ifdef CAM_CFG_RETRY_EN
                                if (attempt_q < ATT_MAX) begin
                                    attempt_q <= attempt_q + ATT_ONE;
                                    state_q   <= S_ISSUE;
                                    wrValid_q <= 1'b1;
                                end else begin
                                    state_q   <= S_ERROR;
                                    busy_q    <= 1'b0;
                                    error_q   <= 1'b1;
                                    errAddr_q <= index_q;
                                end
`else
                                state_q   <= S_ERROR;
                                busy_q    <= 1'b0;
                                error_q   <= 1'b1;
                                errAddr_q <= index_q;
`endif
                            end
                        end
                    end
                    S_DELAY: begin
                        if (delayExpire) begin
                            if (index_q == INDEX_LAST) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_FETCH;
                                index_q <= index_d;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr_o  = index_q;
    assign wr.wr_valid = wrValid_q;
    assign wr.wr_dev   = DEV_ID;
    assign wr.wr_reg   = wrReg_q;
    assign wr.wr_data  = wrData_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_addr_o  = errAddr_q;

endmodule
